exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Multi-cycle sequencer for the 16-bit execute datapath. It fetches one instruction at a time, decodes it, and issues one-cycle enable pulses in order to the register file read port, the ALU operand mux (`en_in`, `alu_in_sel`, `offset`), the ALU and register writeback. It owns the PC, handles jumps and halts, and counts retired instructions.

Parameters:
DWIDTH, 16, instruction and datapath width; instruction format requires 16.
PC_WIDTH, 8, width of PC and instruction address.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  leave IDLE and begin fetching at PC=0
instr_req  output  1  high while in FETCH
instr_addr  output  PC_WIDTH  current PC
instr_valid  input  1  instr holds a valid word; sampled only in FETCH
instr  input  DWIDTH  instruction word
rf_rd_en  output  1  register file read pulse
rd_addr  output  3  destination/first source register, instr[10:8]
rs_addr  output  3  second source register, instr[7:5]
mux_en  output  1  operand mux enable, drives `en_in`
alu_in_sel  output  1  0 = register operand, 1 = immediate
offset  output  8  immediate, instr[7:0]
alu_en  output  1  ALU execute pulse
alu_op  output  3  ALU operation code
wb_en  output  1  writeback pulse
wb_addr  output  3  writeback register (= rd_addr)
busy  output  1  high in any state except IDLE and HALT
halted  output  1  high in HALT
illegal  output  1  one-cycle pulse on an undefined opcode
retire_cnt  output  16  retired-instruction count, wraps at 0xFFFF

Behaviour:
- Reset (asynchronous, on `rst_n` low): state=IDLE, PC=0, `retire_cnt`=0, latched instruction=0, every output 0. Reset mid-instruction aborts it; no pulse is issued after reset.
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- States: IDLE, FETCH, DECODE, READ, MUX, EXEC, WB, HALT.
- IDLE: `start`=1 -> FETCH. Otherwise stay.
- FETCH: `instr_req`=1.
  - `instr_valid`=1: latch `instr`, go to DECODE.
  - Otherwise wait, with no timeout.
  - `start` is ignored in every state except IDLE.
- DECODE: opcode = instr[15:11].
  - NOP 00000: PC+1, retire, -> FETCH.
  - ADD 00001, SUB 00010, AND 00011, OR 00100: `alu_op`=0..3, `alu_in_sel`=0. PC+1, -> READ.
  - ADDI 00101: `alu_op`=0, `alu_in_sel`=1. PC+1, -> READ.
  - JMP 01000: PC=instr[7:0] (zero-extended or truncated to PC_WIDTH), retire, -> FETCH.
  - HALT 11111: retire, -> HALT. PC is not incremented.
  - Any other opcode: `illegal` pulse, handled as NOP.
- READ: `rf_rd_en` pulse -> MUX.
- MUX: `mux_en` pulse -> EXEC. The mux registers its operands, so `alu_a`/`alu_b` are valid during EXEC.
- EXEC: `alu_en` pulse -> WB.
- WB: `wb_en` pulse, retire -> FETCH.
- Held stable from DECODE until the next FETCH: `rd_addr`, `rs_addr`, `wb_addr`, `offset`, `alu_op`, `alu_in_sel`.
- PC increments modulo 2^PC_WIDTH: 0xFF wraps to 0x00.
- Latency: ALU instruction = 6 cycles from the FETCH cycle that sees `instr_valid` through WB, i.e. 5 cycles after acceptance. NOP/JMP = 2 cycles.
- Retire: `retire_cnt` += 1 in the retiring cycle; wraps 0xFFFF -> 0.
- HALT: `halted`=1, `busy`=0. Exits only on reset.
- Each enable pulse (`rf_rd_en`, `mux_en`, `alu_en`, `wb_en`) is high exactly one cycle per ALU instruction. At most one of them is high in any cycle.

Decomposition:
- Package `exec_pkg`: state encoding, opcode constants, `alu_op` codes, instruction field bit positions.
- Sub-module `instr_decode`: combinational; opcode -> {is_alu, is_imm, is_jmp, is_halt, is_illegal, alu_op}. Instantiated once in `exec_ctrl`.

Test Plan:
- ADD instr 0x0940 (rd=1, rs=2) with `instr_valid` held high -> `rf_rd_en`, `mux_en`, `alu_en`, `wb_en` in consecutive cycles 2/3/4/5 after acceptance; `alu_in_sel`=0; `wb_addr`=1; PC 0->1; `retire_cnt`=1.
- ADDI 0x2A7F -> `alu_in_sel`=1, `offset`=0x7F, `rd_addr`=2, `alu_op`=0; the same 6-cycle pulse train.
- JMP 0x40FF at PC=5 -> no `rf_rd_en`/`mux_en`/`alu_en`/`wb_en` pulses; next `instr_addr`=0xFF; a following NOP wraps PC to 0x00.
- Opcode 0x3000, then HALT 0xF800 -> one `illegal` pulse; then `halted`=1, `busy`=0, `instr_req`=0 for 20 cycles; `start` pulses are ignored.
- `instr_valid` held low for 7 cycles in FETCH -> state held, `instr_req`=1 throughout, no other pulses.
- `rst_n` asserted during MUX of an ADD -> all outputs 0 immediately; after release, IDLE with PC=0 and `retire_cnt`=0; no `alu_en` pulse follows.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage sequencer: FSM states, opcodes,
// ALU operation codes and instruction field positions.
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_READ,
        ST_MUX,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned RD_MSB  = 10;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_MSB  = 7;
    localparam int unsigned RS_LSB  = 5;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier for exec_ctrl.
module instr_decode
    import exec_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_alu,
    output logic       is_imm,
    output logic       is_jmp,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [2:0] alu_op
);

    always_comb begin
        is_alu     = 1'b0;
        is_imm     = 1'b0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1;     end
            OP_JMP:  is_jmp = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execute sequencer: fetch, decode, then one-cycle enables to
// register read, operand mux, ALU and writeback. Owns PC and retire count.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_valid,
    input  logic [DWIDTH-1:0]   instr,
    output logic                rf_rd_en,
    output logic [2:0]          rd_addr,
    output logic [2:0]          rs_addr,
    output logic                mux_en,
    output logic                alu_in_sel,
    output logic [7:0]          offset,
    output logic                alu_en,
    output logic [2:0]          alu_op,
    output logic                wb_en,
    output logic [2:0]          wb_addr,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [15:0]         retire_cnt
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         retire_q, retire_d;
    logic [DWIDTH-1:0]   instr_q, instr_d;

    logic                dec_is_alu, dec_is_imm, dec_is_jmp, dec_is_halt, dec_is_illegal;
    logic [2:0]          dec_alu_op;
    logic [PC_WIDTH-1:0] pc_inc, jmp_target;

    instr_decode u_instr_decode (
        .opcode     (instr_q[OPC_MSB:OPC_LSB]),
        .is_alu     (dec_is_alu),
        .is_imm     (dec_is_imm),
        .is_jmp     (dec_is_jmp),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal),
        .alu_op     (dec_alu_op)
    );

    assign pc_inc = pc_q + PC_WIDTH'(1);

    // Jump target is the 8-bit immediate, zero-extended or truncated to the PC.
    always_comb begin
        jmp_target = '0;
        for (int unsigned i = 0; i < PC_WIDTH && i < 8; i++) begin
            jmp_target[i] = instr_q[IMM_LSB + i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            retire_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
            instr_q  <= instr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = retire_q;
        instr_d  = instr_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_is_halt) begin
                    retire_d = retire_q + 16'd1;
                    state_d  = ST_HALT;
                end else if (dec_is_jmp) begin
                    pc_d     = jmp_target;
                    retire_d = retire_q + 16'd1;
                    state_d  = ST_FETCH;
                end else if (dec_is_alu) begin
                    pc_d    = pc_inc;
                    state_d = ST_READ;
                end else begin
                    // NOP and undefined opcodes retire immediately.
                    pc_d     = pc_inc;
                    retire_d = retire_q + 16'd1;
                    state_d  = ST_FETCH;
                end
            end
            ST_READ:  state_d = ST_MUX;
            ST_MUX:   state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB: begin
                retire_d = retire_q + 16'd1;
                state_d  = ST_FETCH;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_req  = (state_q == ST_FETCH);
        rf_rd_en   = (state_q == ST_READ);
        mux_en     = (state_q == ST_MUX);
        alu_en     = (state_q == ST_EXEC);
        wb_en      = (state_q == ST_WB);
        busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted     = (state_q == ST_HALT);
        illegal    = (state_q == ST_DECODE) && dec_is_illegal;
        instr_addr = pc_q;
        rd_addr    = instr_q[RD_MSB:RD_LSB];
        rs_addr    = instr_q[RS_MSB:RS_LSB];
        wb_addr    = instr_q[RD_MSB:RD_LSB];
        offset     = instr_q[IMM_MSB:IMM_LSB];
        alu_op     = dec_alu_op;
        alu_in_sel = dec_is_imm;
        retire_cnt = retire_q;
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomized self-checking bench for exec_ctrl against an instruction-level model.
module tb_exec_ctrl;

    localparam int unsigned PCW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           instr_valid = 1'b0;
    logic [15:0]    instr = '0;
    logic           instr_req, rf_rd_en, mux_en, alu_in_sel, alu_en, wb_en;
    logic           busy, halted, illegal;
    logic [PCW-1:0] instr_addr;
    logic [2:0]     rd_addr, rs_addr, alu_op, wb_addr;
    logic [7:0]     offset;
    logic [15:0]    retire_cnt;

    exec_ctrl #(.DWIDTH(16), .PC_WIDTH(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr(instr),
        .rf_rd_en(rf_rd_en), .rd_addr(rd_addr), .rs_addr(rs_addr),
        .mux_en(mux_en), .alu_in_sel(alu_in_sel), .offset(offset),
        .alu_en(alu_en), .alu_op(alu_op), .wb_en(wb_en), .wb_addr(wb_addr),
        .busy(busy), .halted(halted), .illegal(illegal), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    logic [3:0]  pulse_v;
    logic [52:0] all_out;
    assign pulse_v = {rf_rd_en, mux_en, alu_en, wb_en};
    assign all_out = {instr_req, instr_addr, rf_rd_en, rd_addr, rs_addr, mux_en, alu_in_sel,
                      offset, alu_en, alu_op, wb_en, wb_addr, busy, halted, illegal, retire_cnt};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned pc_m  = 0;
    int unsigned ret_m = 0;

    typedef enum {K_NOP, K_ALU, K_JMP, K_HALT, K_ILL} kind_e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_e kind_of(input logic [15:0] w);
        int unsigned op = int'(w[15:11]);
        if (op == 0) return K_NOP;
        if (op >= 1 && op <= 5) return K_ALU;
        if (op == 8) return K_JMP;
        if (op == 31) return K_HALT;
        return K_ILL;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("reset_outs", 64'(all_out), 64'd0);
        rst_n = 1'b1;
        pc_m = 0;
        ret_m = 0;
        repeat (2) begin
            @(negedge clk);
            check_eq("idle_outs", 64'(all_out), 64'd0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_req", 64'(instr_req), 64'd1);
        check_eq("start_pc", 64'(instr_addr), 64'd0);
    endtask

    // Entry and exit: at a falling edge with the DUT waiting in fetch.
    task automatic run_instr(input logic [15:0] w, input int unsigned wait_cycles);
        kind_e       k  = kind_of(w);
        int unsigned op = int'(w[15:11]);
        logic [2:0]  exp_op = (op == 5) ? 3'd0 : 3'(op - 1);
        for (int unsigned i = 0; i < wait_cycles; i++) begin
            check_eq("wait_req", 64'(instr_req), 64'd1);
            check_eq("wait_pulses", 64'({pulse_v, illegal}), 64'd0);
            check_eq("wait_pc", 64'(instr_addr), 64'(pc_m));
            instr_valid = 1'b0;
            instr = 16'($urandom);
            start = 1'($urandom);
            @(negedge clk);
        end
        check_eq("fetch_req", 64'(instr_req), 64'd1);
        check_eq("fetch_pc", 64'(instr_addr), 64'(pc_m));
        check_eq("fetch_retire", 64'(retire_cnt), 64'(ret_m));
        instr = w;
        instr_valid = 1'b1;
        start = 1'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        check_eq("dec_illegal", 64'(illegal), 64'(k == K_ILL));
        check_eq("dec_pulses", 64'(pulse_v), 64'd0);
        check_eq("dec_req", 64'(instr_req), 64'd0);
        check_eq("dec_rd", 64'(rd_addr), 64'(w[10:8]));
        check_eq("dec_off", 64'(offset), 64'(w[7:0]));
        case (k)
            K_NOP, K_ILL: begin pc_m = (pc_m + 1) % (1 << PCW); ret_m = (ret_m + 1) & 16'hFFFF; end
            K_JMP:        begin pc_m = int'(w[7:0]) % (1 << PCW); ret_m = (ret_m + 1) & 16'hFFFF; end
            K_HALT:       ret_m = (ret_m + 1) & 16'hFFFF;
            K_ALU:        pc_m = (pc_m + 1) % (1 << PCW);
            default:      ;
        endcase
        if (k == K_ALU) begin
            for (int unsigned s = 0; s < 4; s++) begin
                start = 1'($urandom);
                @(negedge clk);
                check_eq("alu_pulse", 64'(pulse_v), 64'(4'b1000 >> s));
                check_eq("alu_illegal", 64'(illegal), 64'd0);
                check_eq("alu_op", 64'(alu_op), 64'(exp_op));
                check_eq("alu_in_sel", 64'(alu_in_sel), 64'(op == 5));
                check_eq("alu_addrs", 64'({rd_addr, rs_addr, wb_addr, offset}),
                         64'({w[10:8], w[7:5], w[10:8], w[7:0]}));
                check_eq("alu_busy", 64'(busy), 64'd1);
            end
            ret_m = (ret_m + 1) & 16'hFFFF;
        end
        if (k == K_HALT) begin
            for (int unsigned c = 0; c < 20; c++) begin
                start = 1'($urandom);
                @(negedge clk);
                check_eq("halt_flags", 64'({halted, busy, instr_req}), 64'(3'b100));
                check_eq("halt_pulses", 64'({pulse_v, illegal}), 64'd0);
                check_eq("halt_retire", 64'(retire_cnt), 64'(ret_m));
            end
            start = 1'b0;
        end else begin
            start = 1'b0;
            @(negedge clk);
            check_eq("next_req", 64'(instr_req), 64'd1);
            check_eq("next_pc", 64'(instr_addr), 64'(pc_m));
            check_eq("next_retire", 64'(retire_cnt), 64'(ret_m));
        end
    endtask

    task automatic random_program(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            logic [15:0] w  = 16'($urandom);
            int unsigned r  = $urandom_range(0, 7);
            int unsigned op;
            if (r < 6)       op = r;
            else if (r == 6) op = 8;
            else             op = $urandom_range(0, 30);
            w[15:11] = 5'(op);
            run_instr(w, $urandom_range(0, 3));
        end
    endtask

    task automatic reset_in_mux();
        instr = 16'h0940;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_read", 64'(rf_rd_en), 64'd1);
        @(negedge clk);
        check_eq("mid_mux", 64'(mux_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_outs", 64'(all_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pc_m = 0;
        ret_m = 0;
        repeat (6) begin
            @(negedge clk);
            check_eq("post_reset_outs", 64'(all_out), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        do_start();
        run_instr(16'h0940, 0);
        run_instr(16'h2A7F, 1);
        run_instr(16'h0000, 7);
        while (pc_m != 5) run_instr(16'h0000, 0);
        run_instr(16'h40FF, 0);
        check_eq("jmp_target", 64'(instr_addr), 64'hFF);
        run_instr(16'h0000, 0);
        check_eq("pc_wrap", 64'(instr_addr), 64'h00);
        random_program(300);

        do_reset();
        do_start();
        reset_in_mux();

        do_reset();
        do_start();
        run_instr(16'h3000, 0);
        run_instr(16'hF800, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
